// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency fetch lookup,
// decode-stage misprediction detection and redirect, plus performance counters.
module branch_predictor #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pcF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] pcD,
  input  logic        branchD,
  input  logic        actual_takenD,
  input  logic [31:0] actual_targetD,
  output logic        pred_takenF,
  output logic [31:0] pred_targetF,
  output logic        mispredictD,
  output logic [31:0] redirect_pcD,
  output logic [31:0] branch_cnt,
  output logic [31:0] miss_cnt
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = 30 - INDEX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [INDEX_W-1:0] idx_f, idx_d;
  logic [TAG_W-1:0]   tag_f, tag_d;
  logic               hit_f, hit_d;

  logic               pred_takenD_q;
  logic [31:0]        pred_targetD_q;

  logic               upd_en, tgt_wr, ctr_wr, inval;
  logic [1:0]         ctr_nxt;
  logic [31:0]        branch_cnt_q, branch_cnt_d;
  logic [31:0]        miss_cnt_q, miss_cnt_d;

  // Fetch-side lookup reads registered state only, so a same-cycle update
  // at the same index is seen one cycle later (read-old-data).
  assign idx_f        = pcF[INDEX_W+1:2];
  assign tag_f        = pcF[31:INDEX_W+2];
  assign hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign pred_takenF  = hit_f && ctr_q[idx_f][1];
  assign pred_targetF = pred_takenF ? target_q[idx_f] : pcF + 32'd4;

  assign idx_d = pcD[INDEX_W+1:2];
  assign tag_d = pcD[31:INDEX_W+2];
  assign hit_d = valid_q[idx_d] && (tag_q[idx_d] == tag_d);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_takenD_q  <= 1'b0;
      pred_targetD_q <= 32'd0;
    end else if (flushD) begin
      pred_takenD_q  <= 1'b0;
      pred_targetD_q <= 32'd0;
    end else if (!stallD) begin
      pred_takenD_q  <= pred_takenF;
      pred_targetD_q <= pred_targetF;
    end
  end

  assign mispredictD = branchD
                     ? ((pred_takenD_q != actual_takenD) ||
                        (pred_takenD_q && actual_takenD && (pred_targetD_q != actual_targetD)))
                     : pred_takenD_q;

  assign redirect_pcD = (branchD && actual_takenD) ? actual_targetD : pcD + 32'd8;

  // NOTE: every variable assigned here gets a default first, otherwise an
  // unassigned path would infer a latch.
  always_comb begin
    upd_en  = !stallD && branchD;
    tgt_wr  = upd_en && actual_takenD;
    ctr_wr  = upd_en && (hit_d || actual_takenD);
    inval   = !stallD && !branchD && pred_takenD_q && hit_d;
    ctr_nxt = ctr_q[idx_d];
    if (!hit_d) begin
      ctr_nxt = 2'd2;
    end else if (actual_takenD) begin
      if (ctr_q[idx_d] != 2'd3) ctr_nxt = ctr_q[idx_d] + 2'd1;
    end else begin
      if (ctr_q[idx_d] != 2'd0) ctr_nxt = ctr_q[idx_d] - 2'd1;
    end
  end

  // NOTE: only valid bits and counters are reset; tags and targets are
  // meaningless while their entry is invalid, so they stay reset-free.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'd1;
    end else begin
      if (tgt_wr)     valid_q[idx_d] <= 1'b1;
      else if (inval) valid_q[idx_d] <= 1'b0;
      if (ctr_wr)     ctr_q[idx_d]   <= ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (tgt_wr) begin
      tag_q[idx_d]    <= tag_d;
      target_q[idx_d] <= actual_targetD;
    end
  end

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (upd_en && (branch_cnt_q != 32'hFFFF_FFFF))
      branch_cnt_d = branch_cnt_q + 32'd1;
    if (mispredictD && !stallD && (miss_cnt_q != 32'hFFFF_FFFF))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      branch_cnt_q <= 32'd0;
      miss_cnt_q   <= 32'd0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: behavioural table model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_branch_predictor;

  localparam int N = 64;
  localparam logic [31:0] X0 = 32'h0040_0010;
  localparam logic [31:0] T0 = 32'h0040_0100;
  localparam logic [31:0] X1 = 32'h0040_0020;
  localparam logic [31:0] T1 = 32'h0040_0200;
  localparam logic [31:0] Z  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] pcF = X0;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic [31:0] pcD = Z;
  logic        branchD = 1'b0;
  logic        actual_takenD = 1'b0;
  logic [31:0] actual_targetD = 32'd0;
  logic        pred_takenF;
  logic [31:0] pred_targetF;
  logic        mispredictD;
  logic [31:0] redirect_pcD;
  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_W(6)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .pcF            (pcF),
    .stallD         (stallD),
    .flushD         (flushD),
    .pcD            (pcD),
    .branchD        (branchD),
    .actual_takenD  (actual_takenD),
    .actual_targetD (actual_targetD),
    .pred_takenF    (pred_takenF),
    .pred_targetF   (pred_targetF),
    .mispredictD    (mispredictD),
    .redirect_pcD   (redirect_pcD),
    .branch_cnt     (branch_cnt),
    .miss_cnt       (miss_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one slot per word-address modulo table size.
  bit          m_valid  [N];
  logic [31:0] m_tag    [N];
  logic [31:0] m_target [N];
  int          m_cnt    [N];
  bit          m_ptD;
  logic [31:0] m_tgtD;
  logic [31:0] m_bc, m_mc;

  function automatic int unsigned slot(input logic [31:0] pc);
    return (pc / 4) % N;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == pc / (4 * N));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_pred(pc) ? m_target[slot(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_misp();
    if (!branchD) return m_ptD;
    if (m_ptD != actual_takenD) return 1'b1;
    return m_ptD && actual_takenD && (m_tgtD != actual_targetD);
  endfunction

  function automatic logic [31:0] m_redir();
    return (branchD && actual_takenD) ? actual_targetD : pcD + 32'd8;
  endfunction

  always @(posedge clk or negedge resetn) begin
    int unsigned s;
    if (!resetn) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] <= 1'b0;
        m_cnt[i]   <= 1;
      end
      m_ptD  <= 1'b0;
      m_tgtD <= 32'd0;
      m_bc   <= 32'd0;
      m_mc   <= 32'd0;
    end else begin
      s = slot(pcD);
      if (!stallD && branchD) begin
        if (m_bc != 32'hFFFF_FFFF) m_bc <= m_bc + 1;
        if (m_hit(pcD)) begin
          if (actual_takenD) begin
            m_cnt[s]    <= (m_cnt[s] >= 3) ? 3 : m_cnt[s] + 1;
            m_target[s] <= actual_targetD;
          end else begin
            m_cnt[s] <= (m_cnt[s] <= 0) ? 0 : m_cnt[s] - 1;
          end
        end else if (actual_takenD) begin
          m_valid[s]  <= 1'b1;
          m_tag[s]    <= pcD / (4 * N);
          m_target[s] <= actual_targetD;
          m_cnt[s]    <= 2;
        end
      end
      if (!stallD && !branchD && m_ptD && m_hit(pcD)) m_valid[s] <= 1'b0;
      if (!stallD && m_misp() && (m_mc != 32'hFFFF_FFFF)) m_mc <= m_mc + 1;
      if (flushD) begin
        m_ptD  <= 1'b0;
        m_tgtD <= 32'd0;
      end else if (!stallD) begin
        m_ptD  <= m_pred(pcF);
        m_tgtD <= m_ptgt(pcF);
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    check("model_pred_takenF",  {31'd0, pred_takenF}, {31'd0, m_pred(pcF)});
    check("model_pred_targetF", pred_targetF,          m_ptgt(pcF));
    check("model_mispredictD",  {31'd0, mispredictD},  {31'd0, m_misp()});
    check("model_redirect_pcD", redirect_pcD,          m_redir());
    check("model_branch_cnt",   branch_cnt,            m_bc);
    check("model_miss_cnt",     miss_cnt,              m_mc);
  end

  task automatic cyc(input logic [31:0] pf, input logic st, input logic fl,
                     input logic [31:0] pd, input logic br, input logic tk,
                     input logic [31:0] tg);
    @(negedge clk);
    pcF            = pf;
    stallD         = st;
    flushD         = fl;
    pcD            = pd;
    branchD        = br;
    actual_takenD  = tk;
    actual_targetD = tg;
    #3;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #3;
    check("rst_pred_takenF",  {31'd0, pred_takenF}, 32'd0);
    check("rst_pred_targetF", pred_targetF,         32'h0040_0014);
    check("rst_mispredictD",  {31'd0, mispredictD}, 32'd0);
    check("rst_branch_cnt",   branch_cnt,           32'd0);
    check("rst_miss_cnt",     miss_cnt,             32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #3;
    check("post_rst_pred_takenF", {31'd0, pred_takenF}, 32'd0);
    check("post_rst_mispredictD", {31'd0, mispredictD}, 32'd0);

    // Train X0 taken twice: allocate at 2, then 3
    cyc(X0, 0, 0, X0, 1, 1, T0);
    check("c1_mispredictD",  {31'd0, mispredictD}, 32'd1);
    check("c1_redirect_pcD", redirect_pcD,         T0);
    cyc(X0, 0, 0, X0, 1, 1, T0);
    check("c2_pred_takenF",  {31'd0, pred_takenF}, 32'd1);
    check("c2_pred_targetF", pred_targetF,         T0);

    // Strongly taken resolved not taken: 3 -> 2 still taken, 2 -> 1 not taken
    cyc(X0, 0, 0, X0, 1, 0, T0);
    check("c3_mispredictD",  {31'd0, mispredictD}, 32'd1);
    check("c3_redirect_pcD", redirect_pcD,         32'h0040_0018);
    cyc(X0, 0, 0, X0, 1, 0, T0);
    check("c4_pred_takenF",  {31'd0, pred_takenF}, 32'd1);
    cyc(X0, 0, 0, Z, 0, 0, 32'd0);
    check("c5_pred_takenF",  {31'd0, pred_takenF}, 32'd0);
    check("c5_pred_targetF", pred_targetF,         32'h0040_0014);
    check("c5_redirect_pcD", redirect_pcD,         32'h0040_0008);

    // Retrain, then stall with a branch in decode, then flush under stall
    cyc(X0, 0, 0, X0, 1, 1, T0);
    cyc(X0, 0, 0, X0, 1, 1, T0);
    check("c7_pred_takenF",  {31'd0, pred_takenF}, 32'd1);
    cyc(Z,  1, 0, X0, 1, 0, T0);
    check("c8_mispredictD",  {31'd0, mispredictD}, 32'd1);
    cyc(X0, 1, 0, X0, 1, 0, T0);
    check("c9_pred_takenF",  {31'd0, pred_takenF}, 32'd1);
    check("c9_mispredictD",  {31'd0, mispredictD}, 32'd1);
    check("c9_branch_cnt",   branch_cnt,           32'd6);
    cyc(X0, 1, 1, Z, 0, 0, 32'd0);
    check("c10_miss_cnt",    miss_cnt,             32'd7);
    cyc(Z,  0, 0, Z, 0, 0, 32'd0);
    check("c11_mispredictD", {31'd0, mispredictD}, 32'd0);

    // Same-index update and lookup in one cycle
    cyc(X0, 0, 0, X0, 1, 0, T0);
    check("c12_mispredictD",  {31'd0, mispredictD}, 32'd0);
    check("c12_redirect_pcD", redirect_pcD,         32'h0040_0018);
    cyc(X0, 0, 0, X0, 1, 0, T0);
    check("c13_pred_takenF",  {31'd0, pred_takenF}, 32'd1);
    cyc(X0, 0, 0, Z, 0, 0, 32'd0);
    check("c14_pred_takenF",  {31'd0, pred_takenF}, 32'd0);

    // Predicted-taken non-branch invalidates its entry
    cyc(X1, 0, 0, X1, 1, 1, T1);
    check("c15_redirect_pcD", redirect_pcD,         T1);
    cyc(X1, 0, 0, Z, 0, 0, 32'd0);
    check("c16_pred_takenF",  {31'd0, pred_takenF}, 32'd1);
    check("c16_pred_targetF", pred_targetF,         T1);
    cyc(Z,  0, 0, X1, 0, 0, 32'd0);
    check("c17_mispredictD",  {31'd0, mispredictD}, 32'd1);
    check("c17_redirect_pcD", redirect_pcD,         32'h0040_0028);
    check("c17_miss_cnt",     miss_cnt,             32'd10);
    cyc(X1, 0, 0, Z, 0, 0, 32'd0);
    check("c18_pred_takenF",  {31'd0, pred_takenF}, 32'd0);
    check("c18_miss_cnt",     miss_cnt,             32'd11);
    check("c18_branch_cnt",   branch_cnt,           32'd9);

    // Reset asserted while a taken branch update is presented
    @(negedge clk);
    resetn = 1'b0;
    cyc(X0, 0, 0, X0, 1, 1, T0);
    check("c19_branch_cnt",   branch_cnt,           32'd0);
    @(negedge clk);
    resetn  = 1'b1;
    branchD = 1'b0;
    #3;
    check("c20_pred_takenF",  {31'd0, pred_takenF}, 32'd0);
    check("c20_pred_targetF", pred_targetF,         32'h0040_0014);
    cyc(X0, 0, 0, Z, 0, 0, 32'd0);
    check("c21_pred_takenF",  {31'd0, pred_takenF}, 32'd0);
    check("c21_branch_cnt",   branch_cnt,           32'd0);

    repeat (2) @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter INDEX_W, default 6, meaning log2 of BTB/counter table entries (64).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port pcF  input  32  fetch-stage PC to look up.
REQ-005 SHALL have port stallD  input  1  hold the decode-stage prediction record and suppress table update.
REQ-006 SHALL have port flushD  input  1  clear the decode-stage prediction record.
REQ-007 SHALL have port pcD  input  32  PC of the instruction in decode.
REQ-008 SHALL have port branchD  input  1  decode instruction is a conditional branch (beq/bne/blez/bgtz/bltz/bgez/bltzal/bgezal).
REQ-009 SHALL have port actual_takenD  input  1  resolved branch outcome from decode-stage branch resolution.
REQ-010 SHALL have port actual_targetD  input  32  resolved branch target (pcbranchD).
REQ-011 SHALL have port pred_takenF  output  1  prediction for pcF.
REQ-012 SHALL have port pred_targetF  output  32  predicted target for pcF.
REQ-013 SHALL have port mispredictD  output  1  decode-stage redirect request.
REQ-014 SHALL have port redirect_pcD  output  32  corrected PC when mispredictD=1.
REQ-015 SHALL have ports branch_cnt and miss_cnt  output  32 each  performance counters.

Function
REQ-016 SHALL index tables with pc[INDEX_W+1:2] and tag with pc[31:INDEX_W+2]; each entry holds valid, tag, 32-bit target, 2-bit counter.
REQ-017 SHALL drive pred_takenF=1 combinationally iff entry valid, tag matches pcF, and counter[1]=1; pred_targetF = entry target when pred_takenF=1, else pcF+4.
REQ-018 SHALL register {pred_takenF, pred_targetF} into pred_takenD/pred_targetD each cycle when stallD=0; hold when stallD=1; flushD=1 clears to pred_takenD=0, pred_targetD=0 (flushD wins over stallD).
REQ-019 SHALL assert mispredictD = branchD & (pred_takenD != actual_takenD | (pred_takenD & actual_takenD & pred_targetD != actual_targetD)), or !branchD & pred_takenD.
REQ-020 SHALL drive redirect_pcD = actual_targetD when branchD & actual_takenD, else pcD+8 (past delay slot); redirect_pcD is don't-care-free: always driven by this rule.
REQ-021 SHALL update on a rising edge only when stallD=0 and branchD=1: counter saturating increment on taken (max 3), saturating decrement on not taken (min 0).
REQ-022 SHALL, on taken branch with tag miss or invalid entry, allocate: valid=1, tag, target=actual_targetD, counter=2; on not-taken miss SHALL leave the entry unchanged.
REQ-023 SHALL, on taken branch with tag hit, overwrite target with actual_targetD.
REQ-024 SHALL, when stallD=0, branchD=0 and pred_takenD=1 with tag hit at pcD, clear that entry's valid bit.
REQ-025 SHALL give lookup read-old-data semantics when pcF and the update hit the same index in one cycle.
REQ-026 SHALL increment branch_cnt per update event (REQ-021) and miss_cnt per cycle with mispredictD=1 and stallD=0; both saturate at 32'hFFFFFFFF.
REQ-027 SHALL have zero-cycle lookup latency and one-cycle table update latency.

Reset
REQ-028 SHALL, on resetn=0, asynchronously clear all valid bits, set all counters to 1 (weakly not taken), clear pred_takenD, pred_targetD, branch_cnt, miss_cnt.
REQ-029 SHALL, during and immediately after reset, output pred_takenF=0, pred_targetF=pcF+4, mispredictD=0.
REQ-030 SHALL treat reset mid-update as discarding the update; no partial entry write.

Verification
REQ-031 SHALL test: reset, pcF=0x00400010 -> pred_takenF=0, pred_targetF=0x00400014, counters 0.
REQ-032 SHALL test: branch at 0x00400010 resolved taken to 0x00400100 twice -> entry counter 2 then 3; next lookup pred_takenF=1, pred_targetF=0x00400100.
REQ-033 SHALL test: strongly-taken entry resolved not taken -> mispredictD=1, redirect_pcD=0x00400018, counter 2, still predicts taken; second not-taken -> counter 1, predicts not taken.
REQ-034 SHALL test: stallD=1 with branchD=1 -> no counter change, pred_takenD held, branch_cnt unchanged; flushD=1 with stallD=1 -> pred_takenD=0.
REQ-035 SHALL test: same-index update and lookup in one cycle -> lookup returns pre-update prediction, next cycle returns updated.
REQ-036 SHALL test: pred_takenD=1 on non-branch -> mispredictD=1, redirect_pcD=pcD+8, entry invalidated, miss_cnt +1.
